// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like instruction and data ports to one AXI master.
// One read and one write may be in flight at a time, each with its own FSM.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} wstate_t;

    rstate_t     r_rstate;
    wstate_t     r_wstate;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;
    logic [3:0]  r_arid;
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_awaddr;
    logic [2:0]  r_awsize;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;

    logic w_rd_idle;
    logic w_wr_idle;
    logic w_data_rd_grant;
    logic w_inst_grant;
    logic w_data_wr_grant;
    logic w_r_done;
    logic w_b_done;
    logic w_unused_ok;

    // A data read waits for the write FSM to drain so it can never overtake a pending store.
    assign w_rd_idle       = (r_rstate == R_IDLE) && !reset;
    assign w_wr_idle       = (r_wstate == W_IDLE) && !reset;
    assign w_data_rd_grant = w_rd_idle && w_wr_idle && data_sram_req && !data_sram_wr;
    assign w_inst_grant    = w_rd_idle && inst_sram_req && !w_data_rd_grant;
    assign w_data_wr_grant = w_wr_idle && data_sram_req && data_sram_wr;
    assign w_r_done        = (r_rstate == R_R) && rvalid && !reset;
    assign w_b_done        = (r_wstate == W_B) && bvalid && !reset;

    assign inst_sram_addr_ok = w_inst_grant;
    assign data_sram_addr_ok = w_data_rd_grant || w_data_wr_grant;
    assign inst_sram_data_ok = w_r_done && !rid[0];
    assign data_sram_data_ok = (w_r_done && rid[0]) || w_b_done;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = 8'd0;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign awid    = 4'd1;
    assign awaddr  = r_awaddr;
    assign awlen   = 8'd0;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_awvalid;
    assign wid     = 4'd1;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    assign w_unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid[3:1],
                           rresp, rlast, bid, bresp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= 32'd0;
            r_arsize  <= 3'd0;
            r_arid    <= 4'd0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_data_rd_grant || w_inst_grant) begin
                        r_araddr  <= w_data_rd_grant ? data_sram_addr : inst_sram_addr;
                        r_arsize  <= {1'b0, (w_data_rd_grant ? data_sram_size : inst_sram_size)};
                        r_arid    <= {3'b000, w_data_rd_grant};
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_rstate  <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Address and data channels complete independently; B is awaited only after both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_awsize  <= 3'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= 32'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_data_wr_grant) begin
                        r_awaddr  <= data_sram_addr;
                        r_awsize  <= {1'b0, data_sram_size};
                        r_wstrb   <= data_sram_wstrb;
                        r_wdata   <= data_sram_wdata;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wstate  <= W_AW_W;
                    end
                end
                W_AW_W: begin
                    if (awready) r_awvalid <= 1'b0;
                    if (wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
                        r_bready <= 1'b1;
                        r_wstate <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Random core + AXI slave traffic against a transaction-level model of the bridge:
// grants, completions, channel valids and latched fields are predicted every cycle.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding read, one outstanding write.
    bit          m_rd_busy, m_ar_pend, m_rd_port;
    logic [31:0] m_rd_addr;
    logic [1:0]  m_rd_size;
    bit          m_wr_busy, m_aw_pend, m_w_pend;
    logic [31:0] m_wr_addr, m_wr_data;
    logic [3:0]  m_wr_strb;
    logic [1:0]  m_wr_size;

    // Core-side agents: 0 idle, 1 requesting, 2 waiting for data_ok.
    int          ci_state, cd_state;
    logic [31:0] ci_addr, cd_addr, cd_wdata;
    logic        cd_wr;
    logic [1:0]  cd_size;
    logic [3:0]  cd_strb;
    int          n_inst_done, n_drd_done, n_wr_done, n_resets, n_raw_blocks;

    task automatic clear_model();
        m_rd_busy = 0; m_ar_pend = 0; m_rd_port = 0;
        m_wr_busy = 0; m_aw_pend = 0; m_w_pend = 0;
        ci_state = 0; cd_state = 0;
    endtask

    task automatic run_cycles(input int n, input int p_arr, input int p_rv, input int p_awr,
                              input int p_wr, input int p_bv, input int p_req,
                              input int p_rst_pm);
        for (int c = 0; c < n; c++) begin
            logic e_rd_idle, e_wr_idle, e_drd, e_iok, e_dwr, e_rdone, e_bdone, e_idok, e_ddok;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 999) < p_rst_pm);
            if (ci_state == 0 && $urandom_range(0, 99) < p_req) begin
                ci_state = 1;
                ci_addr  = ($urandom_range(0, 3) == 0) ? 32'h1C00_0000 : ($urandom & ~32'h3);
            end
            if (cd_state == 0 && $urandom_range(0, 99) < p_req) begin
                cd_state = 1;
                cd_wr    = $urandom_range(0, 1);
                cd_addr  = ($urandom_range(0, 3) == 0) ? 32'h0000_0100 : ($urandom & ~32'h3);
                cd_size  = 2'($urandom_range(0, 2));
                cd_strb  = 4'($urandom);
                cd_wdata = $urandom;
            end
            inst_sram_req   = (ci_state == 1);
            inst_sram_wr    = 1'($urandom);
            inst_sram_size  = 2'd2;
            inst_sram_wstrb = 4'($urandom);
            inst_sram_addr  = ci_addr;
            inst_sram_wdata = $urandom;
            data_sram_req   = (cd_state == 1);
            data_sram_wr    = cd_wr;
            data_sram_size  = cd_size;
            data_sram_wstrb = cd_strb;
            data_sram_addr  = cd_addr;
            data_sram_wdata = cd_wdata;
            arready = ($urandom_range(0, 99) < p_arr);
            rvalid  = ($urandom_range(0, 99) < p_rv);
            rdata   = $urandom;
            rid     = (m_rd_busy && !m_ar_pend) ? {3'($urandom), m_rd_port} : 4'($urandom);
            rresp   = 2'($urandom);
            rlast   = 1'($urandom);
            awready = ($urandom_range(0, 99) < p_awr);
            wready  = ($urandom_range(0, 99) < p_wr);
            bvalid  = ($urandom_range(0, 99) < p_bv);
            bid     = 4'($urandom);
            bresp   = 2'($urandom);
            #1;
            e_rd_idle = !m_rd_busy && !reset;
            e_wr_idle = !m_wr_busy && !reset;
            e_drd     = e_rd_idle && e_wr_idle && data_sram_req && !cd_wr;
            e_iok     = e_rd_idle && inst_sram_req && !e_drd;
            e_dwr     = e_wr_idle && data_sram_req && cd_wr;
            e_rdone   = !reset && m_rd_busy && !m_ar_pend && rvalid;
            e_bdone   = !reset && m_wr_busy && !m_aw_pend && !m_w_pend && bvalid;
            e_idok    = e_rdone && !m_rd_port;
            e_ddok    = (e_rdone && m_rd_port) || e_bdone;
            if (e_iok && data_sram_req && !cd_wr && m_wr_busy) n_raw_blocks++;

            chk("inst_addr_ok", inst_sram_addr_ok, e_iok);
            chk("data_addr_ok", data_sram_addr_ok, e_drd || e_dwr);
            chk("inst_data_ok", inst_sram_data_ok, e_idok);
            chk("data_data_ok", data_sram_data_ok, e_ddok);
            chk("arvalid", arvalid, m_rd_busy && m_ar_pend);
            chk("rready", rready, m_rd_busy && !m_ar_pend);
            chk("awvalid", awvalid, m_wr_busy && m_aw_pend);
            chk("wvalid", wvalid, m_wr_busy && m_w_pend);
            chk("bready", bready, m_wr_busy && !m_aw_pend && !m_w_pend);
            if (m_rd_busy && m_ar_pend) begin
                chk("araddr", araddr, m_rd_addr);
                chk("arid", arid, {3'b000, m_rd_port});
                chk("arsize", arsize, {1'b0, m_rd_size});
            end
            if (m_wr_busy && m_aw_pend) begin
                chk("awaddr", awaddr, m_wr_addr);
                chk("awsize", awsize, {1'b0, m_wr_size});
            end
            if (m_wr_busy && m_w_pend) begin
                chk("wdata", wdata, m_wr_data);
                chk("wstrb", wstrb, m_wr_strb);
            end
            if (e_idok) chk("inst_rdata", inst_sram_rdata, rdata);
            if (e_rdone && m_rd_port) chk("data_rdata", data_sram_rdata, rdata);

            if (reset) begin
                n_resets++;
                clear_model();
            end else begin
                if (ci_state == 2 && e_idok) begin ci_state = 0; n_inst_done++; end
                if (ci_state == 1 && e_iok) ci_state = 2;
                if (cd_state == 2 && e_ddok) begin
                    cd_state = 0;
                    if (cd_wr) n_wr_done++; else n_drd_done++;
                end
                if (cd_state == 1 && (e_drd || e_dwr)) cd_state = 2;
                if (m_rd_busy) begin
                    if (m_ar_pend) begin
                        if (arready) m_ar_pend = 0;
                    end else if (rvalid) m_rd_busy = 0;
                end else if (e_drd || e_iok) begin
                    m_rd_busy = 1; m_ar_pend = 1; m_rd_port = e_drd;
                    m_rd_addr = e_drd ? cd_addr : ci_addr;
                    m_rd_size = e_drd ? cd_size : 2'd2;
                end
                if (m_wr_busy) begin
                    if (m_aw_pend || m_w_pend) begin
                        if (awready) m_aw_pend = 0;
                        if (wready)  m_w_pend  = 0;
                    end else if (bvalid) m_wr_busy = 0;
                end else if (e_dwr) begin
                    m_wr_busy = 1; m_aw_pend = 1; m_w_pend = 1;
                    m_wr_addr = cd_addr; m_wr_data = cd_wdata;
                    m_wr_strb = cd_strb; m_wr_size = cd_size;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        ci_addr = 0; cd_addr = 0; cd_wdata = 0; cd_wr = 0; cd_size = 0; cd_strb = 0;
        n_inst_done = 0; n_drd_done = 0; n_wr_done = 0; n_resets = 0; n_raw_blocks = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
        chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
        chk("const_ar", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        chk("const_aw", {awlen, awburst, awlock, awcache, awprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        chk("const_w", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
        reset = 1'b0;
        run_cycles(2000, 70, 50, 70, 70, 60, 60, 3);
        run_cycles(1500, 10, 30, 20, 80, 40, 80, 0);
        run_cycles(1500, 90, 90, 90, 20, 90, 90, 5);
        $display("traffic: inst=%0d data_rd=%0d data_wr=%0d resets=%0d raw_blocks=%0d",
                 n_inst_done, n_drd_done, n_wr_done, n_resets, n_raw_blocks);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters: none; all AXI widths fixed (ID 4, addr 32, data 32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_sram_req, inst_sram_wr, inst_sram_size[1:0], inst_sram_wstrb[3:0], inst_sram_addr[31:0], inst_sram_wdata[31:0]  input  core instruction request.
REQ-005 inst_sram_addr_ok, inst_sram_data_ok  output  1 each  instruction request accepted / read data returned.
REQ-006 inst_sram_rdata  output  32  instruction read data.
REQ-007 data_sram_req, data_sram_wr, data_sram_size[1:0], data_sram_wstrb[3:0], data_sram_addr[31:0], data_sram_wdata[31:0]  input  core data request.
REQ-008 data_sram_addr_ok, data_sram_data_ok  output  1 each; data_sram_rdata  output  32.
REQ-009 arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid  output; arready  input.
REQ-010 rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  input; rready  output.
REQ-011 awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  output (AR widths); awready  input.
REQ-012 wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  output; wready  input; bid[3:0], bresp[1:0], bvalid  input; bready  output.

Function
REQ-013 Constants: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, awid=wid=4'd1, wlast=1; arsize/awsize = {1'b0, size}.
REQ-014 Read FSM states: R_IDLE, R_AR, R_R; write FSM states: W_IDLE, W_AW_W, W_B; the two FSMs are independent.
REQ-015 Inst port always treated as read; inst_sram_wr ignored.
REQ-016 In R_IDLE, a data read (data_sram_req && !data_sram_wr) wins over an inst read; the winner gets addr_ok combinationally that cycle, the loser gets addr_ok=0.
REQ-017 Data read is blocked (addr_ok=0) while write FSM is not W_IDLE (RAW safety); inst read then takes the grant.
REQ-018 On read grant: latch addr, size, arid (0 inst, 1 data); next state R_AR; arvalid=1 exactly while in R_AR, fields stable.
REQ-019 R_AR -> R_R on arvalid && arready; rready=1 exactly while in R_R.
REQ-020 In R_R on rvalid: data_ok pulses 1 cycle to the port selected by rid[0] (0 inst, 1 data), rdata forwarded combinationally to that port's rdata; -> R_IDLE.
REQ-021 In W_IDLE, data_sram_req && data_sram_wr -> data_sram_addr_ok=1 same cycle; latch addr, size, wstrb, wdata; -> W_AW_W.
REQ-022 W_AW_W: awvalid and wvalid both set on entry; each drops independently on its own handshake; -> W_B when both handshakes done (same or different cycles).
REQ-023 W_B: bready=1; on bvalid -> data_sram_data_ok pulses 1 cycle, -> W_IDLE.
REQ-024 Data port grants at most one request per cycle; a data write and an inst read may both be granted in the same cycle.
REQ-025 Only one outstanding read and one outstanding write at any time; a new request is granted the cycle the corresponding FSM is in idle, not before.
REQ-026 rresp, bresp, rlast, bid ignored; rvalid/bvalid outside R_R/W_B ignored.
REQ-027 All AXI outputs registered except constants; addr_ok, data_ok and forwarded rdata combinational.

Reset
REQ-028 While reset=1 (sync): FSMs -> R_IDLE/W_IDLE; arvalid, awvalid, wvalid, rready, bready = 0; all addr_ok/data_ok = 0; latched regs cleared to 0.
REQ-029 Reset mid-transaction abandons it; no data_ok issued for the abandoned request.

Verification
REQ-030 Inst read 0x1C000000, arready=1 next cycle, rvalid 2 cycles later with rdata 0x02800C0C, rid=0 -> arid=0, inst_sram_data_ok pulses once with rdata 0x02800C0C.
REQ-031 Inst and data reads same cycle -> data_sram_addr_ok=1, inst_sram_addr_ok=0, arid=1; inst granted the cycle after data_ok.
REQ-032 Data write addr 0x100, wdata 0xDEADBEEF, wstrb 0xF; awready 3 cycles before wready -> awvalid drops first, wvalid held, W_B entered after wready; data_ok on bvalid.
REQ-033 Data read to 0x100 issued while write pending -> data addr_ok stays 0 until cycle after write data_ok; concurrent inst read still granted.
REQ-034 arvalid held 5 cycles with arready=0 -> araddr/arid stable throughout; no second grant.
REQ-035 reset=1 during R_R and W_B -> next cycle all valids/readies 0; later rvalid/bvalid produce no data_ok.
